// File: rtl/io_bus_arbiter.sv
// Two-requester round-robin arbiter in front of a single external IO bus, plus an io_irq synchronizer.
// Optional BUS-state watchdog enabled by defining IO_ARB_TIMEOUT_EN.
module io_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES  = 1023,
    parameter int unsigned IRQ_SYNC_STAGES = 2
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        m0_req,
    input  logic        m0_rw,
    input  logic [15:0] m0_address,
    input  logic [1:0]  m0_byte_enable,
    input  logic [15:0] m0_write_data,
    output logic        m0_done,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_rw,
    input  logic [15:0] m1_address,
    input  logic [1:0]  m1_byte_enable,
    input  logic [15:0] m1_write_data,
    output logic        m1_done,
    output logic        m1_err,
    output logic [15:0] rd_data,
    output logic        io_bus_enable,
    output logic        io_rw,
    output logic [15:0] io_address,
    output logic [1:0]  io_byte_enable,
    output logic [15:0] io_write_data,
    input  logic [15:0] io_read_data,
    input  logic        io_acknowledge,
    input  logic        io_irq,
    output logic        irq_sync
);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic        rw_q, rw_d;
    logic [15:0] addr_q, addr_d;
    logic [1:0]  be_q, be_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rd_q, rd_d;
    logic        winner;
    logic        in_bus, in_done;

`ifdef IO_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
`endif

    // On a tie the requester that was not served last wins.
    assign winner = (m0_req && m1_req) ? ~last_q : m1_req;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
`ifdef IO_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    state_d = S_BUS;
                    owner_d = winner;
                    rw_d    = winner ? m1_rw          : m0_rw;
                    addr_d  = winner ? m1_address     : m0_address;
                    be_d    = winner ? m1_byte_enable : m0_byte_enable;
                    wdata_d = winner ? m1_write_data  : m0_write_data;
`ifdef IO_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_BUS: begin
`ifdef IO_ARB_TIMEOUT_EN
                cnt_d = cnt_q + 16'd1;
`endif
                if (io_acknowledge) begin
                    state_d = S_DONE;
                    rd_d    = rw_q ? io_read_data : '0;
`ifdef IO_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = S_DONE;
                    rd_d    = '1;
                    err_d   = 1'b1;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                last_d  = owner_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
`ifdef IO_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
`ifdef IO_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign in_bus  = (state_q == S_BUS);
    assign in_done = (state_q == S_DONE);

    assign io_bus_enable  = in_bus;
    assign io_rw          = in_bus & rw_q;
    assign io_address     = in_bus ? addr_q  : '0;
    assign io_byte_enable = in_bus ? be_q    : '0;
    assign io_write_data  = in_bus ? wdata_q : '0;

    assign m0_done = in_done & ~owner_q;
    assign m1_done = in_done &  owner_q;
    assign rd_data = in_done ? rd_q : '0;

`ifdef IO_ARB_TIMEOUT_EN
    assign m0_err = in_done & ~owner_q & err_q;
    assign m1_err = in_done &  owner_q & err_q;
`else
    assign m0_err = 1'b0;
    assign m1_err = 1'b0;
`endif

    logic [IRQ_SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[IRQ_SYNC_STAGES-2:0], io_irq};
        end
    end

    assign irq_sync = sync_q[IRQ_SYNC_STAGES-1];

endmodule
